// File: rtl/lsu_ctrl.sv
// rtl/lsu_ctrl.sv - load/store unit controller: alignment check, byte-lane steering, bus timeout
// Single-transaction FSM between the pipeline and a one-outstanding memory bus.
module lsu_ctrl #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        we,
  input  logic [2:0]  op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        exc_adel,
  output logic        exc_ades,
  output logic        bus_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [1:0]  ext_addr,
  output logic [2:0]  ext_con,
  output logic [31:0] ext_din,
  input  logic [31:0] ext_dout
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, ACCESS, EXTEND, RESP, ERR} state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic          we_q;
  logic          busy_q, done_q, exc_adel_q, exc_ades_q, bus_err_q;
  logic [31:0]   rdata_q;
  logic          mem_req_q, mem_we_q;
  logic [31:0]   mem_addr_q, mem_wdata_q;
  logic [3:0]    mem_be_q;
  logic [1:0]    ext_addr_q;
  logic [2:0]    ext_con_q;
  logic [31:0]   ext_din_q;

  logic          misaligned;
  logic [3:0]    mem_be_d;
  logic [31:0]   mem_wdata_d;

  always_comb begin
    misaligned = 1'b0;
    case (op)
      3'd1, 3'd2: misaligned = 1'b0;
      3'd3, 3'd4: misaligned = addr[0];
      default:    misaligned = |addr[1:0];
    endcase
  end

  // Loads always fetch the full word; the extender picks the lane afterwards.
  always_comb begin
    mem_be_d    = 4'b1111;
    mem_wdata_d = wdata;
    if (we) begin
      case (op)
        3'd1, 3'd2: begin
          mem_be_d    = 4'b0001 << addr[1:0];
          mem_wdata_d = {4{wdata[7:0]}};
        end
        3'd3, 3'd4: begin
          mem_be_d    = addr[1] ? 4'b1100 : 4'b0011;
          mem_wdata_d = {2{wdata[15:0]}};
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      exc_adel_q  <= 1'b0;
      exc_ades_q  <= 1'b0;
      bus_err_q   <= 1'b0;
      rdata_q     <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
      ext_addr_q  <= '0;
      ext_con_q   <= '0;
      ext_din_q   <= '0;
    end else begin
      done_q     <= 1'b0;
      exc_adel_q <= 1'b0;
      exc_ades_q <= 1'b0;
      bus_err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req) begin
            we_q   <= we;
            busy_q <= 1'b1;
            if (misaligned) begin
              state_q    <= ERR;
              done_q     <= 1'b1;
              exc_adel_q <= ~we;
              exc_ades_q <= we;
            end else begin
              state_q     <= ACCESS;
              cnt_q       <= '0;
              mem_req_q   <= 1'b1;
              mem_we_q    <= we;
              mem_addr_q  <= {addr[31:2], 2'b00};
              mem_be_q    <= mem_be_d;
              mem_wdata_q <= mem_wdata_d;
              ext_addr_q  <= addr[1:0];
              ext_con_q   <= op;
            end
          end
        end
        ACCESS: begin
          // An ack arriving on the last counted cycle still completes normally.
          if (mem_ack) begin
            mem_req_q <= 1'b0;
            if (we_q) begin
              state_q <= RESP;
              done_q  <= 1'b1;
            end else begin
              ext_din_q <= mem_rdata;
              state_q   <= EXTEND;
            end
          end else if (cnt_q == CNT_LAST) begin
            mem_req_q <= 1'b0;
            state_q   <= RESP;
            done_q    <= 1'b1;
            bus_err_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        EXTEND: begin
          rdata_q <= ext_dout;
          state_q <= RESP;
          done_q  <= 1'b1;
        end
        RESP, ERR: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign rdata     = rdata_q;
  assign exc_adel  = exc_adel_q;
  assign exc_ades  = exc_ades_q;
  assign bus_err   = bus_err_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_be    = mem_be_q;
  assign mem_wdata = mem_wdata_q;
  assign ext_addr  = ext_addr_q;
  assign ext_con   = ext_con_q;
  assign ext_din   = ext_din_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb/tb_lsu_ctrl.sv - directed scoreboard bench for lsu_ctrl
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req, we;
  logic [2:0]  op;
  logic [31:0] addr, wdata;
  logic        busy, done, exc_adel, exc_ades, bus_err;
  logic [31:0] rdata;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic [1:0]  ext_addr;
  logic [2:0]  ext_con;
  logic [31:0] ext_din, ext_dout;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] rd;
    logic        adel;
    logic        ades;
    logic        berr;
    int          lat;
    int          acc;
  } exp_t;
  exp_t sb[$];

  lsu_ctrl #(.TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .op(op), .addr(addr), .wdata(wdata),
    .busy(busy), .done(done), .rdata(rdata), .exc_adel(exc_adel), .exc_ades(exc_ades),
    .bus_err(bus_err), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .ext_addr(ext_addr), .ext_con(ext_con), .ext_din(ext_din), .ext_dout(ext_dout)
  );

  always #5 clk = ~clk;

  // Reference load extender
  logic [7:0]  xb;
  logic [15:0] xh;
  always_comb begin
    xb = ext_din[{ext_addr, 3'b000} +: 8];
    xh = ext_din[{ext_addr[1], 4'b0000} +: 16];
    case (ext_con)
      3'd1:    ext_dout = {24'b0, xb};
      3'd2:    ext_dout = {{24{xb[7]}}, xb};
      3'd3:    ext_dout = {16'b0, xh};
      3'd4:    ext_dout = {{16{xh[15]}}, xh};
      default: ext_dout = ext_din;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic run_txn(input string name, input logic t_we, input logic [2:0] t_op,
                         input logic [31:0] t_addr, input logic [31:0] t_wdata,
                         input logic [31:0] t_rdata, input int ack_cyc, input bit pulse,
                         input int e_lat, input int e_acc, input logic [31:0] e_rd,
                         input logic [31:0] e_maddr, input logic [3:0] e_be,
                         input logic [31:0] e_wd, input logic e_adel, input logic e_ades,
                         input logic e_berr);
    exp_t e;
    exp_t got;
    int   acc = 0;
    bit   seen = 0;
    e.rd = e_rd; e.adel = e_adel; e.ades = e_ades; e.berr = e_berr; e.lat = e_lat; e.acc = e_acc;
    @(negedge clk);
    req = 1'b1; we = t_we; op = t_op; addr = t_addr; wdata = t_wdata; mem_rdata = t_rdata;
    sb.push_back(e);
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      @(negedge clk);
      req = pulse && (k == 2);
      if (done) begin
        got = sb.pop_front();
        chk({name, ".latency"}, 32'(k), 32'(got.lat));
        chk({name, ".access_cycles"}, 32'(acc), 32'(got.acc));
        chk({name, ".rdata"}, rdata, got.rd);
        chk({name, ".flags"}, {29'b0, exc_adel, exc_ades, bus_err},
            {29'b0, got.adel, got.ades, got.berr});
        seen = 1;
        break;
      end
      chk({name, ".flags_idle"}, {29'b0, exc_adel, exc_ades, bus_err}, 32'b0);
      if (mem_req) begin
        acc++;
        if (acc == 1) begin
          chk({name, ".mem_addr"}, mem_addr, e_maddr);
          chk({name, ".mem_be"}, {28'b0, mem_be}, {28'b0, e_be});
          chk({name, ".mem_we"}, {31'b0, mem_we}, {31'b0, t_we});
          chk({name, ".ext_sel"}, {27'b0, ext_addr, ext_con}, {27'b0, t_addr[1:0], t_op});
          if (t_we) chk({name, ".mem_wdata"}, mem_wdata, e_wd);
        end
        mem_ack = (acc == ack_cyc);
      end else begin
        mem_ack = 1'b0;
      end
    end
    mem_ack = 1'b0;
    req = 1'b0;
    chk({name, ".done_seen"}, {31'b0, seen}, 32'd1);
    @(negedge clk);
    chk({name, ".after_done"}, {30'b0, busy, done}, 32'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; req = 1'b0; we = 1'b0; op = '0; addr = '0; wdata = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    repeat (2) @(negedge clk);
    chk("reset.ctrl", {27'b0, busy, done, exc_adel, exc_ades, bus_err}, 32'b0);
    chk("reset.bus", {26'b0, mem_req, mem_we, mem_be}, 32'b0);
    chk("reset.rdata", rdata, 32'b0);
    chk("reset.mem_addr", mem_addr, 32'b0);
    chk("reset.ext", {27'b0, ext_addr, ext_con} | ext_din, 32'b0);
    rst_n = 1'b1;

    // Stray acks while idle must not start anything
    @(negedge clk); mem_ack = 1'b1;
    @(negedge clk); chk("stray_ack", {30'b0, busy, done}, 32'b0);
    mem_ack = 1'b0;

    run_txn("ld_b_sign", 0, 3'd2, 32'h13, 32'h0, 32'h80AA5533, 1, 0, 3, 1,
            32'hFFFFFF80, 32'h10, 4'b1111, 32'h0, 0, 0, 0);
    run_txn("st_half", 1, 3'd3, 32'h22, 32'h0000BEEF, 32'h0, 1, 0, 2, 1,
            32'hFFFFFF80, 32'h20, 4'b1100, 32'hBEEFBEEF, 0, 0, 0);
    run_txn("ld_misal", 0, 3'd4, 32'h41, 32'h0, 32'h0, 1, 0, 1, 0,
            32'hFFFFFF80, 32'h0, 4'b0, 32'h0, 1, 0, 0);
    run_txn("st_timeout", 1, 3'd0, 32'h100, 32'h12345678, 32'h0, 0, 0, 17, 16,
            32'hFFFFFF80, 32'h100, 4'b1111, 32'h12345678, 0, 0, 1);
    run_txn("ld_slow_pulse", 0, 3'd3, 32'h6, 32'h0, 32'h1234ABCD, 5, 1, 7, 5,
            32'h00001234, 32'h4, 4'b1111, 32'h0, 0, 0, 0);
    run_txn("ld_word", 0, 3'd0, 32'h8, 32'h0, 32'hDEADBEEF, 1, 0, 3, 1,
            32'hDEADBEEF, 32'h8, 4'b1111, 32'h0, 0, 0, 0);
    run_txn("st_byte3", 1, 3'd1, 32'h3, 32'h000000A5, 32'h0, 1, 0, 2, 1,
            32'hDEADBEEF, 32'h0, 4'b1000, 32'hA5A5A5A5, 0, 0, 0);
    run_txn("st_misal_op5", 1, 3'd5, 32'h2, 32'h0, 32'h0, 1, 0, 1, 0,
            32'hDEADBEEF, 32'h0, 4'b0, 32'h0, 0, 1, 0);
    run_txn("ld_b_zero", 0, 3'd1, 32'h2, 32'h0, 32'h11F02233, 1, 0, 3, 1,
            32'h000000F0, 32'h0, 4'b1111, 32'h0, 0, 0, 0);
    run_txn("ld_ack_last", 0, 3'd4, 32'h2, 32'h0, 32'h80010000, 16, 0, 18, 16,
            32'hFFFF8001, 32'h0, 4'b1111, 32'h0, 0, 0, 0);

    // Reset in the middle of a bus access
    @(negedge clk);
    req = 1'b1; we = 1'b1; op = 3'd0; addr = 32'h40; wdata = 32'h55;
    @(negedge clk); req = 1'b0;
    @(negedge clk);
    chk("rst_mid.req_before", {31'b0, mem_req}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid.async", {30'b0, mem_req, busy}, 32'b0);
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rst_mid.no_done", {30'b0, done, busy}, 32'b0);
    end
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lsu_ctrl.md
LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 16, SHALL set the maximum cycles ACCESS waits for mem_ack before a bus error.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 req  in  1  pipeline request strobe; sampled only in IDLE.
REQ-005 we  in  1  1 = store, 0 = load.
REQ-006 op  in  3  size/extension code: 0 word, 1 byte-zero, 2 byte-sign, 3 half-zero, 4 half-sign, 5-7 treated as word.
REQ-007 addr  in  32  byte address.
REQ-008 wdata  in  32  store data, right-justified.
REQ-009 busy  out  1  high whenever state is not IDLE.
REQ-010 done  out  1  one-cycle completion pulse.
REQ-011 rdata  out  32  extended load result, valid while done=1 and held until the next load completes.
REQ-012 exc_adel / exc_ades  out  1 each  misaligned load / store flag, valid with done.
REQ-013 bus_err  out  1  timeout flag, valid with done.
REQ-014 mem_req, mem_we  out  1 each; mem_addr  out  32; mem_be  out  4; mem_wdata  out  32  memory bus request.
REQ-015 mem_ack  in  1; mem_rdata  in  32  memory bus response.
REQ-016 ext_addr  out  2; ext_con  out  3; ext_din  out  32  drive the load extender; ext_dout  in  32  extender result (combinational).

Function
REQ-017 FSM states SHALL be IDLE, ACCESS, EXTEND, RESP and ERR.
REQ-018 IDLE with req=1: misaligned -> ERR; otherwise latch we/op/addr/wdata and go to ACCESS; req while busy SHALL be ignored.
REQ-019 Misaligned SHALL mean op in {3,4} with addr[0]=1, or op in {0,5,6,7} with addr[1:0]!=0; byte ops are never misaligned.
REQ-020 ACCESS: mem_req=1, mem_addr={addr[31:2],2'b00}, mem_we=latched we; all bus outputs held stable until mem_ack.
REQ-021 ACCESS with mem_ack: load -> capture mem_rdata into ext_din, go to EXTEND; store -> RESP.
REQ-022 Store lanes: byte ops mem_be=4'b0001<<addr[1:0] and mem_wdata={4{wdata[7:0]}}; half ops mem_be=addr[1]?4'b1100:4'b0011 and mem_wdata={2{wdata[15:0]}}; word ops mem_be=4'b1111 and mem_wdata=wdata; for loads mem_be=4'b1111.
REQ-023 ext_addr=latched addr[1:0] and ext_con=latched op, held constant from ACCESS entry through RESP.
REQ-024 EXTEND: rdata<=ext_dout; next state RESP.
REQ-025 RESP: done=1 for exactly one cycle; next state IDLE.
REQ-026 ERR: done=1 with exc_adel (load) or exc_ades (store) for one cycle, no bus request issued; next state IDLE.
REQ-027 ACCESS wait counter SHALL clear on ACCESS entry and increment each cycle without ack; on reaching TIMEOUT-1 without ack: drop mem_req, go to RESP with bus_err=1, rdata unchanged.
REQ-028 mem_ack in the same cycle the counter hits TIMEOUT-1 SHALL win (normal completion, no bus_err).
REQ-029 mem_ack outside ACCESS SHALL be ignored.
REQ-030 Latency from req edge, ack on first ACCESS cycle: store done at cycle +2, load done at cycle +3, misaligned done at cycle +1.
REQ-031 exc_adel, exc_ades and bus_err SHALL be 0 whenever done=0.

Reset
REQ-032 rst_n=0 SHALL immediately force IDLE and zero busy, done, rdata, all exc/bus_err flags, mem_req, mem_we, mem_addr, mem_be, mem_wdata, ext_addr, ext_con, ext_din and the wait counter.
REQ-033 Reset asserted mid-ACCESS SHALL drop mem_req asynchronously; no done pulse for the aborted request.

Verification
REQ-034 Load op=2, addr=0x13, mem_rdata=0x80AA5533 acked on first cycle -> ext_addr=3, rdata=0xFFFFFF80, done at +3.
REQ-035 Store op=3, addr=0x22, wdata=0x0000BEEF -> mem_addr=0x20, mem_be=4'b1100, mem_wdata=0xBEEFBEEF, done at +2.
REQ-036 Load op=4, addr=0x41 -> done at +1 with exc_adel=1, mem_req never asserted.
REQ-037 Store op=0, mem_ack withheld -> mem_req for 16 cycles, then done with bus_err=1, busy low the next cycle.
REQ-038 Load with ack on 5th ACCESS cycle plus req pulsed during busy -> single transaction, second req ignored, done at +7.
REQ-039 rst_n low during ACCESS -> mem_req=0 and busy=0 without waiting for a clock edge, no done pulse.
